// File: rtl/beat_rate_meter.sv
// Heartbeat comparator pulse to beats-per-minute: synchronise, debounce, measure the
// beat-to-beat interval in 1 ms ticks, then divide 60000 by it with a bit-serial divider.
module beat_rate_meter #(
    parameter int unsigned DEBOUNCE_MS = 8,
    parameter int unsigned REFRACT_MS  = 250,
    parameter int unsigned TIMEOUT_MS  = 3000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_ms,
    input  logic       pulse_in,
    output logic       beat,
    output logic [7:0] bpm,
    output logic       bpm_valid,
    output logic       no_signal
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MEAS = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

    localparam int unsigned SW       = $clog2(DEBOUNCE_MS + 1);
    localparam logic [SW-1:0] DEB_LAST = SW'(DEBOUNCE_MS - 1);
    localparam logic [11:0] REFRACT  = 12'(REFRACT_MS);
    localparam logic [11:0] TIMEOUT  = 12'(TIMEOUT_MS);
    localparam logic [15:0] DIVIDEND = 16'd60000;

    logic          sync_meta, sync_q;
    logic          filt_q, filt_d;
    logic [SW-1:0] stab_q, stab_d;
    logic          cand_q, cand_d;
    logic [11:0]   ivl_q, ivl_d;
    logic [1:0]    state_q, state_d;
    logic [11:0]   divisor_q, divisor_d;
    logic [16:0]   rem_q, rem_d;
    logic [15:0]   quo_q, quo_d;
    logic [3:0]    step_q, step_d;
    logic [7:0]    bpm_q, bpm_d;
    logic          bpm_valid_q, bpm_valid_d;
    logic          no_signal_q, no_signal_d;

    logic [16:0]   rem_shift, rem_next;
    logic          rem_ge;
    logic [15:0]   quo_next;
    logic          timeout;

    // A mismatch run of DEBOUNCE_MS ticks moves the filtered level; any match restarts the run.
    always_comb begin
        filt_d = filt_q;
        stab_d = stab_q;
        if (tick_ms) begin
            if (sync_q != filt_q) begin
                if (stab_q == DEB_LAST) begin
                    filt_d = sync_q;
                    stab_d = '0;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end else begin
                stab_d = '0;
            end
        end
        cand_d = filt_d & ~filt_q;
    end

    // One restoring step per clock, dividend bits consumed MSB first.
    always_comb begin
        rem_shift = {rem_q[15:0], DIVIDEND[4'd15 - step_q]};
        rem_ge    = rem_shift >= {5'd0, divisor_q};
        rem_next  = rem_ge ? rem_shift - {5'd0, divisor_q} : rem_shift;
        quo_next  = {quo_q[14:0], rem_ge};
    end

    assign timeout = (ivl_q == TIMEOUT);

    always_comb begin
        state_d     = state_q;
        ivl_d       = (tick_ms && !timeout) ? ivl_q + 12'd1 : ivl_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        step_d      = step_q;
        bpm_d       = bpm_q;
        bpm_valid_d = 1'b0;
        no_signal_d = no_signal_q;
        beat        = 1'b0;
        case (state_q)
            IDLE: begin
                if (cand_q) begin
                    beat    = 1'b1;
                    ivl_d   = '0;
                    state_d = MEAS;
                end
            end
            MEAS: begin
                if (timeout) begin
                    no_signal_d = 1'b1;
                    bpm_d       = '0;
                    state_d     = IDLE;
                    // A coincident candidate restarts measurement as a fresh first beat.
                    if (cand_q) begin
                        beat    = 1'b1;
                        ivl_d   = '0;
                        state_d = MEAS;
                    end
                end else if (cand_q && ivl_q >= REFRACT) begin
                    beat      = 1'b1;
                    divisor_d = ivl_q;
                    ivl_d     = '0;
                    rem_d     = '0;
                    quo_d     = '0;
                    step_d    = '0;
                    state_d   = DIV;
                end
            end
            DIV: begin
                rem_d  = rem_next;
                quo_d  = quo_next;
                step_d = step_q + 4'd1;
                if (step_q == 4'd15) begin
                    bpm_d       = (|quo_next[15:8]) ? 8'hFF : quo_next[7:0];
                    bpm_valid_d = 1'b1;
                    no_signal_d = 1'b0;
                    state_d     = MEAS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta   <= 1'b0;
            sync_q      <= 1'b0;
            filt_q      <= 1'b0;
            stab_q      <= '0;
            cand_q      <= 1'b0;
            ivl_q       <= '0;
            state_q     <= IDLE;
            divisor_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            step_q      <= '0;
            bpm_q       <= '0;
            bpm_valid_q <= 1'b0;
            no_signal_q <= 1'b1;
        end else begin
            sync_meta   <= pulse_in;
            sync_q      <= sync_meta;
            filt_q      <= filt_d;
            stab_q      <= stab_d;
            cand_q      <= cand_d;
            ivl_q       <= ivl_d;
            state_q     <= state_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            step_q      <= step_d;
            bpm_q       <= bpm_d;
            bpm_valid_q <= bpm_valid_d;
            no_signal_q <= no_signal_d;
        end
    end

    assign bpm       = bpm_q;
    assign bpm_valid = bpm_valid_q;
    assign no_signal = no_signal_q;

endmodule

// File: tb/tb_beat_rate_meter.sv
// Bench for beat_rate_meter: tick-level pulse patterns from a table plus random rows,
// checked against a tick-domain model of beats, intervals and timeout.
module tb_beat_rate_meter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_ms;
    logic       pulse_in;
    logic       beat;
    logic [7:0] bpm;
    logic       bpm_valid;
    logic       no_signal;

    always #5 clk = ~clk;

    beat_rate_meter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_ms   (tick_ms),
        .pulse_in  (pulse_in),
        .beat      (beat),
        .bpm       (bpm),
        .bpm_valid (bpm_valid),
        .no_signal (no_signal)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model, one call per 1 ms tick with the level the DUT sees at that tick.
    int m_tick = 0;
    bit m_filt;
    bit hist[$];
    bit m_meas;
    int m_last;
    int m_bpm;
    bit m_nosig;
    int exp_beats[$];  // -1: first beat (no rate), else expected bpm for that beat

    function automatic void model_reset();
        hist.delete();
        m_filt  = 1'b0;
        m_meas  = 1'b0;
        m_last  = 0;
        m_bpm   = 0;
        m_nosig = 1'b1;
        exp_beats.delete();
    endfunction

    function automatic void model_tick(input bit lvl);
        bit flip;
        int iv;
        int q;
        m_tick++;
        hist.push_back(lvl);
        if (hist.size() > 8) void'(hist.pop_front());
        if (m_meas && (m_tick - m_last) == 3000) begin
            m_meas  = 1'b0;
            m_bpm   = 0;
            m_nosig = 1'b1;
        end
        flip = (hist.size() == 8);
        foreach (hist[i]) if (hist[i] == m_filt) flip = 1'b0;
        if (flip) begin
            m_filt = lvl;
            if (lvl) begin
                iv = m_tick - m_last;
                if (!m_meas) begin
                    m_meas = 1'b1;
                    m_last = m_tick;
                    exp_beats.push_back(-1);
                end else if (iv >= 250) begin
                    q = 60000 / iv;
                    if (q > 255) q = 255;
                    m_bpm   = q;
                    m_nosig = 1'b0;
                    m_last  = m_tick;
                    exp_beats.push_back(q);
                end
            end
        end
    endfunction

    // Monitor: pairs each beat with its expectation and times the bpm_valid that follows.
    int pend = -1;
    int pend_bpm = 0;
    int n_valid = 0;

    always @(negedge clk) begin
        int e;
        if (!rst_n) begin
            pend = -1;
        end else begin
            if (pend >= 0) pend++;
            if (bpm_valid) begin
                n_valid++;
                if (pend < 0) begin
                    check("bpm_valid spurious", bpm_valid, 0);
                end else begin
                    check("bpm_valid latency", pend, 17);
                    check("bpm value", bpm, pend_bpm);
                    pend = -1;
                end
            end else if (pend > 17) begin
                check("bpm_valid missing", bpm_valid, 1);
                pend = -1;
            end
            if (beat) begin
                if (exp_beats.size() == 0) begin
                    check("beat spurious", beat, 0);
                end else begin
                    e = exp_beats.pop_front();
                    if (e >= 0) begin
                        pend     = 0;
                        pend_bpm = e;
                    end
                end
            end
        end
    end

    // One tick every 3 clocks; the level is applied early enough to clear the synchroniser.
    task automatic drive_tick(input bit lvl);
        pulse_in = lvl;
        @(negedge clk);
        @(negedge clk);
        tick_ms = 1'b1;
        model_tick(lvl);
        @(negedge clk);
        tick_ms = 1'b0;
    endtask

    task automatic drive_row(input int period, input int high, input int g_at, input int g_len);
        for (int t = 0; t < period; t++)
            drive_tick((t < high) || (t >= g_at && t < g_at + g_len));
    endtask

    typedef struct {
        int period;
        int high;
        int g_at;
        int g_len;
        int exp_bpm;
        int exp_nosig;
    } row_t;

    row_t rows[15];

    initial begin
        int per, hi, ga, gl, nv;
        rows[0]  = '{1000, 100,   0,   0,   0, 1};  // first beat only
        rows[1]  = '{1000, 100,   0,   0,  60, 0};
        rows[2]  = '{ 500, 100,   0,   0,  60, 0};
        rows[3]  = '{ 750, 100,   0,   0, 120, 0};
        rows[4]  = '{1000, 100, 300,   5,  80, 0};  // 5 ms glitch filtered out
        rows[5]  = '{1000, 100, 150,   8,  60, 0};  // 8 ms glitch inside refractory
        rows[6]  = '{1000, 100, 200, 100,  60, 0};  // edge 200 ms after beat ignored
        rows[7]  = '{1000, 100, 400,   8, 150, 0};  // 8 ms glitch accepted at 400 ms
        rows[8]  = '{3100, 100,   0,   0,   0, 1};  // pulses stop, timeout
        rows[9]  = '{ 600, 100,   0,   0,   0, 1};
        rows[10] = '{ 600, 100,   0,   0, 100, 0};
        rows[11] = '{ 250,  20,   0,   0, 100, 0};
        rows[12] = '{ 249,  20,   0,   0, 240, 0};  // exactly 250 ms accepted
        rows[13] = '{ 400,  20,   0,   0, 240, 0};  // 249 ms rejected
        rows[14] = '{ 300,  20,   0,   0,  92, 0};  // 649 ms

        rst_n    = 1'b0;
        tick_ms  = 1'b0;
        pulse_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset beat", beat, 0);
        check("reset bpm", bpm, 0);
        check("reset bpm_valid", bpm_valid, 0);
        check("reset no_signal", no_signal, 1);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (rows[r]) begin
            drive_row(rows[r].period, rows[r].high, rows[r].g_at, rows[r].g_len);
            check($sformatf("row%0d bpm", r), bpm, rows[r].exp_bpm);
            check($sformatf("row%0d no_signal", r), no_signal, rows[r].exp_nosig);
            check($sformatf("row%0d model bpm", r), bpm, m_bpm);
            check($sformatf("row%0d model no_signal", r), no_signal, m_nosig);
            check($sformatf("row%0d beats pending", r), exp_beats.size(), 0);
        end

        for (int r = 0; r < 6; r++) begin
            per = $urandom_range(700, 250);
            hi  = $urandom_range(60, 8);
            ga  = 0;
            gl  = 0;
            if ($urandom_range(1, 0) == 1) begin
                ga = $urandom_range(per - 20, hi + 10);
                gl = $urandom_range(12, 1);
            end
            drive_row(per, hi, ga, gl);
            check($sformatf("rand%0d bpm", r), bpm, m_bpm);
            check($sformatf("rand%0d no_signal", r), no_signal, m_nosig);
            check($sformatf("rand%0d beats pending", r), exp_beats.size(), 0);
        end

        // Reset three clocks into the divide that follows an accepted beat.
        for (int t = 0; t < 8; t++) drive_tick(1'b1);
        check("pre-reset beat", beat, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid-div reset beat", beat, 0);
        check("mid-div reset bpm", bpm, 0);
        check("mid-div reset bpm_valid", bpm_valid, 0);
        check("mid-div reset no_signal", no_signal, 1);
        model_reset();
        pulse_in = 1'b0;
        repeat (4) @(negedge clk);
        nv = n_valid;
        rst_n = 1'b1;
        for (int t = 0; t < 20; t++) drive_tick(1'b0);
        check("post-reset bpm_valid count", n_valid, nv);
        check("post-reset bpm", bpm, 0);
        check("post-reset no_signal", no_signal, 1);
        check("final beats pending", exp_beats.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
